mr_wb_arb: RTL and testbench



---
 rtl/mr_wb_arb.sv | 183 ++++++++++++++++++
 tb/tb_mr_wb_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mr_wb_arb.sv
// Two-master to one-slave pipelined Wishbone arbiter: CYC-granular round-robin grant,
// outstanding-strobe cap and a watchdog that turns a hung slave into an error.
module mr_wb_arb #(
  parameter int unsigned AW        = 30,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst,
  // Master 0 (instruction fetch)
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m0_we_i,
  input  logic            m0_stb_i,
  input  logic            m0_cyc_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_stall_o,
  // Master 1 (load/store)
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic            m1_we_i,
  input  logic            m1_stb_i,
  input  logic            m1_cyc_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_stall_o,
  // Slave port
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_stall_i,
  output logic [1:0]      owner_o
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [OW-1:0] OutstMax = OW'(MAX_OUTST);
  localparam logic [WW-1:0] WdMax    = WW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StFault} state_e;

  state_e         state_q, state_d;
  logic           lg_q, lg_d;
  logic [OW-1:0]  outst_q, outst_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic           flt_new_q, flt_new_d;

  logic own, own_cyc, own_stb, other_cyc, cap_ok, resp, accept, silent, wd_hit;

  // While owning or faulted, lg_q names the master holding the bus.
  assign own       = (state_q == StOwn0) || (state_q == StOwn1);
  assign own_cyc   = lg_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb   = lg_q ? m1_stb_i : m0_stb_i;
  assign other_cyc = lg_q ? m0_cyc_i : m1_cyc_i;
  assign cap_ok    = (outst_q < OutstMax);
  assign resp      = s_ack_i | s_err_i;
  assign accept    = own & own_stb & cap_ok & ~s_stall_i;
  assign silent    = own & own_cyc & (outst_q != '0) & ~resp;
  assign wd_hit    = (TIMEOUT != 0) && silent && ((wd_q + 1'b1) == WdMax);

  assign s_adr_o  = lg_q ? m1_adr_i : m0_adr_i;
  assign s_dat_o  = lg_q ? m1_dat_i : m0_dat_i;
  assign s_sel_o  = lg_q ? m1_sel_i : m0_sel_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      lg_q      <= 1'b1;
      outst_q   <= '0;
      wd_q      <= '0;
      flt_new_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lg_q      <= lg_d;
      outst_q   <= outst_d;
      wd_q      <= wd_d;
      flt_new_q <= flt_new_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = lg_q ? StOwn0 : StOwn1;
          lg_d    = ~lg_q;
        end else if (m0_cyc_i) begin
          state_d = StOwn0;
          lg_d    = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = StOwn1;
          lg_d    = 1'b1;
        end
      end
      StOwn0, StOwn1: begin
        if (!own_cyc) begin
          if (other_cyc) begin
            state_d = lg_q ? StOwn0 : StOwn1;
            lg_d    = ~lg_q;
          end else begin
            state_d = StIdle;
          end
        end else if (wd_hit) begin
          state_d = StFault;
        end
      end
      StFault: begin
        if (!own_cyc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Counters survive only while the same owner keeps CYC; any release or fault aborts them.
    outst_d = '0;
    wd_d    = '0;
    if (own && own_cyc && (state_d == state_q)) begin
      outst_d = outst_q;
      if (accept && !(resp && (outst_q != '0))) begin
        outst_d = outst_q + 1'b1;
      end else if (!accept && resp && (outst_q != '0)) begin
        outst_d = outst_q - 1'b1;
      end
      if (silent) wd_d = wd_q + 1'b1;
    end
    flt_new_d = (state_d == StFault) && (state_q != StFault);
  end

  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;
    owner_o    = 2'b00;
    unique case (state_q)
      StOwn0: begin
        owner_o    = 2'b01;
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i & cap_ok;
        s_we_o     = m0_we_i;
        m0_stall_o = s_stall_i | (outst_q == OutstMax);
        m0_ack_o   = s_ack_i;
        m0_err_o   = s_err_i;
      end
      StOwn1: begin
        owner_o    = 2'b10;
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i & cap_ok;
        s_we_o     = m1_we_i;
        m1_stall_o = s_stall_i | (outst_q == OutstMax);
        m1_ack_o   = s_ack_i;
        m1_err_o   = s_err_i;
      end
      StFault: begin
        if (lg_q) m1_err_o = flt_new_q;
        else      m0_err_o = flt_new_q;
      end
      StIdle: ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mr_wb_arb.sv
// Self-checking bench for mr_wb_arb: reference model compared every cycle, a hand-derived
// vector table, directed corner sequences and randomized traffic.
module tb_mr_wb_arb;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int MO = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [DW/8-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o, m0_stall_o;
  logic m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o, m1_stall_o;
  logic s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_stall_i;
  logic [1:0] owner_o;

  always #5 clk = ~clk;

  mr_wb_arb #(.AW(AW), .DW(DW), .MAX_OUTST(MO), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_sel_i(m0_sel_i), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_sel_i(m1_sel_i), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_stall_i(s_stall_i), .owner_o(owner_o)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Reference model: owner -1 = nobody, 0/1 = that master; fault tracked separately.
  int m_own, m_fo, m_outst, m_silent;
  bit m_flt, m_fresh, m_lg;

  // Values sampled by the last tick
  logic [7:0] o_tab;
  logic [1:0] o_owner;
  logic o_acc, o_scyc, o_m0_ack, o_m1_ack, o_m0_stall, o_m1_stall, o_m1_err;

  typedef struct {
    logic [5:0] in;   // {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall}
    logic [7:0] exp;  // {owner[1:0], s_cyc, s_stb, m0_ack, m1_ack, m0_stall, m1_stall}
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] exp_ctl();
    logic [1:0] ack, err, stall, owner;
    logic scyc, sstb, we, cyc, stb;
    ack = 2'b00; err = 2'b00; stall = 2'b11; owner = 2'b00;
    scyc = 0; sstb = 0; we = 0;
    if (m_own >= 0) begin
      cyc = (m_own == 1) ? m1_cyc_i : m0_cyc_i;
      stb = (m_own == 1) ? m1_stb_i : m0_stb_i;
      scyc = cyc;
      sstb = stb && (m_outst < MO);
      we = (m_own == 1) ? m1_we_i : m0_we_i;
      owner[m_own == 1] = 1'b1;
      stall[m_own == 1] = s_stall_i || (m_outst == MO);
      ack[m_own == 1] = s_ack_i;
      err[m_own == 1] = s_err_i;
    end
    if (m_flt && m_fresh) err[m_fo == 1] = 1'b1;
    return {owner, scyc, sstb, we, ack[0], err[0], stall[0], ack[1], err[1], stall[1]};
  endfunction

  task automatic model_step();
    bit c[2];
    bit s[2];
    bit rsp, acc;
    int o;
    c[0] = m0_cyc_i; c[1] = m1_cyc_i; s[0] = m0_stb_i; s[1] = m1_stb_i;
    rsp = s_ack_i || s_err_i;
    if (rst) begin
      m_own = -1; m_flt = 0; m_fresh = 0; m_lg = 1; m_outst = 0; m_silent = 0;
    end else if (m_flt) begin
      m_fresh = 0;
      if (!c[m_fo]) m_flt = 0;
    end else if (m_own < 0) begin
      if (c[0] && c[1]) m_own = m_lg ? 0 : 1;
      else if (c[0]) m_own = 0;
      else if (c[1]) m_own = 1;
      if (m_own >= 0) m_lg = (m_own == 1);
    end else begin
      o = m_own;
      if (!c[o]) begin
        m_outst = 0; m_silent = 0;
        if (c[1-o]) begin m_own = 1 - o; m_lg = (m_own == 1); end
        else m_own = -1;
      end else begin
        acc = s[o] && (m_outst < MO) && !s_stall_i;
        if (m_outst > 0 && !rsp) m_silent++; else m_silent = 0;
        if (rsp && m_outst > 0) m_outst--;
        if (acc) m_outst++;
        if (m_silent == TO) begin
          m_flt = 1; m_fresh = 1; m_fo = o; m_own = -1; m_outst = 0; m_silent = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    o_tab = {owner_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_stall_o, m1_stall_o};
    o_owner = owner_o; o_acc = s_stb_o & ~s_stall_i; o_scyc = s_cyc_o;
    o_m0_ack = m0_ack_o; o_m1_ack = m1_ack_o; o_m0_stall = m0_stall_o;
    o_m1_stall = m1_stall_o; o_m1_err = m1_err_o;
    if (chk_en) begin
      chk("ctl", {owner_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m0_stall_o,
                  m1_ack_o, m1_err_o, m1_stall_o}, exp_ctl());
      chk("req", {s_adr_o, s_dat_o, s_sel_o},
          m_lg ? {m1_adr_i, m1_dat_i, m1_sel_i} : {m0_adr_i, m0_dat_i, m0_sel_i});
      chk("rdat", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    s_ack_i = 0; s_err_i = 0; s_stall_i = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    tick();
    rst = 0;
  endtask

  vec_t tab[14];
  int acc_n, err_n, err_cyc, held;
  logic stall_s;

  initial begin
    m_own = -1; m_fo = 0; m_outst = 0; m_silent = 0; m_flt = 0; m_fresh = 0; m_lg = 1;
    m0_adr_i = 30'h0000_1111; m1_adr_i = 30'h0222_2222;
    m0_dat_i = 32'hA0A0_0000; m1_dat_i = 32'hB1B1_0001; s_dat_i = 32'hDEAD_BEEF;
    m0_sel_i = 4'h3; m1_sel_i = 4'hC; m0_we_i = 0; m1_we_i = 1;
    do_reset();
    chk_en = 1;

    // Reset state, then a single m1 read, handoff and round-robin tie
    tab[0]  = '{6'b00_11_00, 8'b00_00_00_11};
    tab[1]  = '{6'b00_11_00, 8'b10_11_00_10};
    tab[2]  = '{6'b00_10_00, 8'b10_10_00_10};
    tab[3]  = '{6'b00_10_10, 8'b10_10_01_10};
    tab[4]  = '{6'b11_00_00, 8'b10_00_00_10};
    tab[5]  = '{6'b11_00_00, 8'b01_11_00_01};
    tab[6]  = '{6'b11_00_01, 8'b01_11_00_11};
    tab[7]  = '{6'b00_00_00, 8'b01_00_00_01};
    tab[8]  = '{6'b10_10_00, 8'b00_00_00_11};
    tab[9]  = '{6'b10_10_00, 8'b10_10_00_10};
    tab[10] = '{6'b10_00_00, 8'b10_00_00_10};
    tab[11] = '{6'b10_00_00, 8'b01_10_00_01};
    tab[12] = '{6'b00_00_00, 8'b01_00_00_01};
    tab[13] = '{6'b00_00_00, 8'b00_00_00_11};
    for (int i = 0; i < 14; i++) begin
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i, s_stall_i} = tab[i].in;
      tick();
      chk($sformatf("row%0d", i), o_tab, tab[i].exp);
    end

    // Tie right after reset: m0 wins, handoff to m1, then m0 wins the next tie
    do_reset();
    m0_cyc_i = 1; m1_cyc_i = 1;
    tick();
    tick(); chk("tie_first", o_owner, 2'b01);
    for (int c = 2; c < 5; c++) tick();
    m0_cyc_i = 0;
    tick(); chk("tie_drop_cycle", o_owner, 2'b01);
    tick(); chk("tie_handoff", o_owner, 2'b10);
    m1_cyc_i = 0;
    tick(); tick(); chk("tie_idle", o_owner, 2'b00);
    m0_cyc_i = 1; m1_cyc_i = 1;
    tick(); tick(); chk("tie_rr", o_owner, 2'b01);

    // Outstanding cap: 4 accepted, stall from the 5th, one ack frees one slot
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; acc_n = 0; stall_s = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c >= 1) acc_n += int'(o_acc);
      if (c == 5) stall_s = o_m0_stall;
    end
    chk("cap_accepts", acc_n, 4);
    chk("cap_stall", stall_s, 1'b1);
    acc_n = 0;
    s_ack_i = 1; tick(); acc_n += int'(o_acc);
    s_ack_i = 0; tick(); acc_n += int'(o_acc);
    tick(); acc_n += int'(o_acc);
    chk("cap_after_ack", acc_n, 1);
    m0_cyc_i = 0; m0_stb_i = 0; tick(); tick();

    // Accept and ack together at outst=2 leaves it at 2
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1;
    tick(); tick(); tick();
    s_ack_i = 1; tick(); s_ack_i = 0;
    acc_n = 0;
    for (int c = 4; c < 8; c++) begin
      tick();
      acc_n += int'(o_acc);
      if (c == 6) stall_s = o_m1_stall;
    end
    chk("same_cycle_accepts", acc_n, 2);
    chk("same_cycle_stall", stall_s, 1'b1);

    // Spurious acks: not forwarded while idle, no underflow while owning
    do_reset();
    s_ack_i = 1; tick();
    chk("spurious_idle_ack", {o_m0_ack, o_m1_ack}, 2'b00);
    s_ack_i = 0; m0_cyc_i = 1;
    tick();
    s_ack_i = 1; tick(); s_ack_i = 0;
    m0_stb_i = 1; acc_n = 0;
    for (int c = 0; c < 6; c++) begin tick(); acc_n += int'(o_acc); end
    chk("spurious_no_underflow", acc_n, 4);

    // Watchdog: m1 hangs with one strobe, faults, m0 held off until m1 lets go
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    m0_cyc_i = 1; err_n = 0; err_cyc = -1; held = 0;
    for (int c = 1; c < 14; c++) begin
      m1_stb_i = (c == 1);
      tick();
      if (o_m1_err) begin err_n++; if (err_cyc < 0) err_cyc = c; end
      if (o_owner == 2'b01) held++;
      if (c == 10) chk("wd_fault_cyc", {o_scyc, o_owner}, 3'b000);
    end
    m1_cyc_i = 0;
    tick(); if (o_owner == 2'b01) held++;
    tick(); if (o_owner == 2'b01) held++;
    chk("wd_err_pulses", err_n, 1);
    chk("wd_err_cycle", err_cyc, 10);
    chk("wd_m0_held_off", held, 0);
    tick(); chk("wd_m0_granted", o_owner, 2'b01);

    // Abort: m0 drops CYC with 3 outstanding, late ack is discarded and outst restarts at 0
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    for (int c = 0; c < 4; c++) tick();
    m0_cyc_i = 0; m0_stb_i = 0; tick();
    s_ack_i = 1; tick();
    chk("abort_late_ack", {o_m0_ack, o_m1_ack}, 2'b00);
    s_ack_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    tick(); acc_n = 0;
    for (int c = 0; c < 6; c++) begin tick(); acc_n += int'(o_acc); end
    chk("abort_outst_cleared", acc_n, 4);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(7) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i & $urandom_range(1);
      m1_stb_i = m1_cyc_i & $urandom_range(1);
      m0_we_i = $urandom_range(1); m1_we_i = $urandom_range(1);
      m0_adr_i = AW'($urandom); m1_adr_i = AW'($urandom);
      m0_dat_i = $urandom; m1_dat_i = $urandom; s_dat_i = $urandom;
      m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
      s_ack_i = ($urandom_range(2) == 0);
      s_err_i = ($urandom_range(31) == 0);
      s_stall_i = ($urandom_range(3) == 0);
      rst = ($urandom_range(499) == 0);
      tick();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
